// File: rtl/spm_ctrl.sv
// spm_ctrl: sequencer for an external serial-parallel multiplier (SPM).
// Accepts a signed multiplicand a and a multiplier b, then drives the SPM:
// one clear cycle, then 2*W+1 shift cycles with b fed serially LSB first.
// The serial product bits are collected into a 2*W-bit result, which is
// offered with a valid/ready handshake.
// Build option: define SPM_CTRL_SIGNED_EN to sign-extend b (signed x signed);
// when it is left undefined, b is zero-extended (signed x unsigned).
module spm_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   spm_x,
  output logic           spm_y,
  output logic           spm_clr,
  input  logic           spm_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod
);

  localparam int PW = 2 * W;
  localparam int CW = $clog2(2 * W + 2);
  localparam logic [CW-1:0] LAST = CW'(PW);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   y_sr;
  logic [PW-1:0]   b_ext;
  logic            accept;

  assign accept = in_valid && in_ready;

`ifdef SPM_CTRL_SIGNED_EN
  assign b_ext = {{W{b[W-1]}}, b};
`else
  assign b_ext = {{W{1'b0}}, b};
`endif

  // The multiplier bit is only meaningful while shifting; y_sr[0] is the
  // bit for the current shift cycle.
  assign spm_y = (state == SHIFT) && y_sr[0];

  // Next-state logic for the IDLE -> CLEAR -> SHIFT -> DONE sequence.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // state_next unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (accept)        state_next = CLEAR;
      CLEAR:                      state_next = SHIFT;
      SHIFT:   if (cnt == LAST)   state_next = DONE;
      DONE:    if (out_ready)     state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Operand latch, multiplier shift register, shift counter and product
  // collection. The extended b is shifted arithmetically, so in the final
  // shift cycle y_sr[0] already holds the extension bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      y_sr  <= '0;
      spm_x <= '0;
      prod  <= '0;
    end else begin
      if (accept) begin
        spm_x <= a;
        y_sr  <= b_ext;
      end
      if (state == CLEAR) cnt <= '0;
      if (state == SHIFT) begin
        cnt  <= cnt + CW'(1);
        y_sr <= {y_sr[PW-1], y_sr[PW-1:1]};
        // The SPM output lags its input by one cycle, so the bit present
        // in shift cycle 0 carries nothing and is skipped.
        if (cnt != '0) prod <= {spm_p, prod[PW-1:1]};
      end
    end
  end

  // Registered handshake and clear flags, derived from the next state so
  // they line up with the state register; they take their reset values
  // while rst is low and settle one edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      spm_clr   <= 1'b1;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      spm_clr   <= (state_next == CLEAR);
    end
  end

endmodule

// File: doc/spm_ctrl.md
SPM_CTRL -- requirements
Module: spm_ctrl

Interface
REQ-001 SHALL have parameter W, default 8: operand width in bits; the product is 2*W bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; every flop is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous reset, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operand pair a/b is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: high only in IDLE.
REQ-006 SHALL have ports a and b, input, W bits each: a is the signed multiplicand; b is the serialised multiplier.
REQ-007 SHALL have port spm_x, output, W bits: latched a, driven to the SPM parallel input.
REQ-008 SHALL have port spm_y, output, 1 bit: serial multiplier bit to the SPM, LSB first.
REQ-009 SHALL have port spm_clr, output, 1 bit: active-high clear to the SPM.
REQ-010 SHALL have port spm_p, input, 1 bit: serial product bit from the SPM.
REQ-011 SHALL have port out_valid, output, 1 bit: product is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the product.
REQ-013 SHALL have port prod, output, 2*W bits: assembled product.

Function
REQ-014 SHALL implement the FSM IDLE -> CLEAR -> SHIFT -> DONE -> IDLE.
REQ-015 SHALL accept operands on the edge where in_valid && in_ready: latch a into spm_x and the 2*W-bit extended b into the y shift register, then go to CLEAR.
REQ-016 CLEAR SHALL last exactly 1 cycle with spm_clr=1; spm_clr SHALL be 0 in every other state.
REQ-017 SHIFT SHALL last exactly 2*W+1 cycles, counted k=0..2*W, by a counter of ceil(log2(2*W+2)) bits.
REQ-018 In SHIFT cycle k<2*W, spm_y SHALL equal extended b bit k; in cycle k=2*W, spm_y SHALL equal the extension bit.
REQ-019 On the edge ending SHIFT cycle k, for k=1..2*W, SHALL shift spm_p into prod at the MSB (right shift), so that prod[0] holds product bit 0 at the end of SHIFT; the edge ending cycle 0 SHALL NOT capture.
REQ-020 out_valid SHALL be 1 only in DONE and SHALL rise exactly 2*W+2 edges after the accepting edge (18 for W=8).
REQ-021 prod SHALL be held stable while out_valid=1.
REQ-022 SHALL leave DONE on the edge where out_ready=1; with out_ready stuck at 0, SHALL stay in DONE indefinitely.
REQ-023 out_ready=1 on the first DONE cycle SHALL give exactly one DONE cycle; in_ready SHALL rise on the following cycle.
REQ-024 in_valid outside IDLE SHALL be ignored, and a/b changes after acceptance SHALL have no effect.
REQ-025 spm_x SHALL hold its value from acceptance until the next acceptance.
REQ-026 prod SHALL be the 2*W LSBs of the product; no overflow is possible.

Reset
REQ-027 While rst=0, SHALL asynchronously force state=IDLE, counter=0, prod=0, spm_x=0, spm_y=0, spm_clr=1, in_ready=0 and out_valid=0.
REQ-028 Reset during any state SHALL abort the operation with no partial out_valid; after rst deasserts, the FSM SHALL be IDLE with in_ready=1 on the next cycle.

Configuration
REQ-029 With macro SPM_CTRL_SIGNED_EN defined, b SHALL be sign-extended (bits W..2*W-1 = b[W-1]), giving a full signed x signed product.
REQ-030 With SPM_CTRL_SIGNED_EN undefined, b SHALL be zero-extended, giving a signed(a) x unsigned(b) product; the FSM and timing SHALL be identical in both builds.

Verification
REQ-031 SHALL cover: a=3, b=5, out_ready=1 -> prod=0x000F, with out_valid rising 18 edges after acceptance.
REQ-032 SHALL cover: a=0xFF, b=0xFF -> prod=0x0001 with SPM_CTRL_SIGNED_EN; prod=0xFF01 without it.
REQ-033 SHALL cover: a=0x7F, b=0x80, signed build -> prod=0xC080.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles after out_valid -> prod stable, in_ready=0, and exactly one transfer when out_ready rises.
REQ-035 SHALL cover: rst pulsed low in SHIFT cycle 7 -> all outputs at reset values immediately; a new a=2, b=2 -> prod=0x0004.
REQ-036 SHALL cover: in_valid held high through a whole operation with a/b changing -> only the pair present at acceptance is used.
